// File: rtl/net_tx_pkt_buffer_pkg.sv
// Shared types and helpers for the TX packet buffer: write FSM states,
// pointer sizing, keep popcount and runt padding mask.
package net_buf_pkg;

    // Widest keep vector the helpers accept (DATA_W up to 1024).
    localparam int KEEP_MAX = 128;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DROP
    } wr_state_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int popcount(input logic [KEEP_MAX-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n += int'(keep[i]);
        end
        return n;
    endfunction

    function automatic logic [KEEP_MAX-1:0] keep_pad(input logic [KEEP_MAX-1:0] keep,
                                                     input int min_bytes);
        logic [KEEP_MAX-1:0] mask;
        mask = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i < min_bytes) begin
                mask[i] = 1'b1;
            end
        end
        return keep | mask;
    endfunction

endpackage

// File: rtl/net_tx_pkt_buffer_if.sv
// AXI-Stream style beat bus used on both sides of the TX packet buffer.
interface net_tx_pkt_buffer_if #(
    parameter int DATA_W = 512
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/net_tx_pkt_buffer_ram.sv
// Simple dual-port storage for buffered beats; one write and one registered read per cycle.
module net_buf_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 577
) (
    input  logic                     net_clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge net_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/net_tx_pkt_buffer.sv
// Store-and-forward TX packet buffer: pads runts, drops oversize/overflowing
// packets whole and releases only fully committed packets to the MAC.
module net_tx_pkt_buffer
    import net_buf_pkg::*;
#(
    parameter int DATA_W          = 512,
    parameter int DEPTH           = 256,
    parameter int MAX_PKT_BEATS   = 32,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                     net_clk,
    input  logic                     sys_reset,
    net_tx_pkt_buffer_if.slave       s_axis,
    net_tx_pkt_buffer_if.master      m_axis,
    output logic [31:0]              pkt_sent_cnt,
    output logic [31:0]              pkt_drop_cnt,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = ptr_w(DEPTH);
    localparam int BC_W   = $clog2(MAX_PKT_BEATS + 1);

    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

    // ---------------- write side ----------------
    wr_state_e         state_q, state_d;
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              wr_tmp_q, wr_tmp_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;
    logic              s_ready_q;

    logic              beat_in;
    logic              full;
    logic              too_long;
    logic              pad_en;
    logic              ram_we;
    logic [KEEP_W-1:0] wr_keep;
    logic [DATA_W-1:0] wr_data;

    assign beat_in  = s_axis.tvalid & s_ready_q;
    assign full     = (wr_tmp_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign too_long = beat_cnt_q == BC_W'(MAX_PKT_BEATS);
    assign pad_en   = s_axis.tlast &&
                      ((int'(beat_cnt_q) * KEEP_W + popcount(KEEP_MAX'(s_axis.tkeep))) < MIN_FRAME_BYTES);
    assign wr_keep  = pad_en ? KEEP_W'(keep_pad(KEEP_MAX'(s_axis.tkeep), MIN_FRAME_BYTES))
                             : s_axis.tkeep;

    // Padded bytes must go out as zero, whatever the source left in them.
    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_pad
        assign wr_data[gi*8 +: 8] = (pad_en && !s_axis.tkeep[gi]) ? 8'h00 : s_axis.tdata[gi*8 +: 8];
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_tmp_d   = wr_tmp_q;
        beat_cnt_d = beat_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ram_we     = 1'b0;
        case (state_q)
            IDLE, ACCEPT: begin
                if (beat_in) begin
                    if (full || too_long) begin
                        wr_tmp_d   = wr_ptr_q;
                        beat_cnt_d = '0;
                        if (s_axis.tlast) begin
                            drop_cnt_d = drop_cnt_q + 32'd1;
                            state_d    = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        ram_we   = 1'b1;
                        wr_tmp_d = wr_tmp_q + PW'(1);
                        if (s_axis.tlast) begin
                            wr_ptr_d   = wr_tmp_q + PW'(1);
                            beat_cnt_d = '0;
                            state_d    = IDLE;
                        end else begin
                            beat_cnt_d = beat_cnt_q + BC_W'(1);
                            state_d    = ACCEPT;
                        end
                    end
                end
            end
            DROP: begin
                if (beat_in && s_axis.tlast) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge net_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            wr_tmp_q   <= '0;
            beat_cnt_q <= '0;
            drop_cnt_q <= '0;
            s_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_tmp_q   <= wr_tmp_d;
            beat_cnt_q <= beat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            s_ready_q  <= 1'b1;
        end
    end

    // ---------------- storage ----------------
    logic [$bits(beat_t)-1:0] ram_rdata;
    beat_t                    ram_rd;
    logic                     issue;

    assign ram_rd = ram_rdata;

    net_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_ram (
        .net_clk (net_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_tmp_q[AW-1:0]),
        .wr_data ({s_axis.tlast, wr_keep, wr_data}),
        .rd_en   (issue),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_rdata)
    );

    // ---------------- read side ----------------
    // RAM output bypasses the skid when it is empty, so the first beat is
    // visible one cycle after the read is issued.
    beat_t       sk_q [2];
    beat_t       sk_d [2];
    logic [1:0]  sk_cnt_q, sk_cnt_d;
    logic        rd_vld_q;
    logic [31:0] sent_cnt_q, sent_cnt_d;
    logic        out_vld;
    beat_t       out_beat;
    logic        pop;

    always_comb begin
        out_vld  = (sk_cnt_q != 2'd0) | rd_vld_q;
        out_beat = (sk_cnt_q != 2'd0) ? sk_q[0] : (rd_vld_q ? ram_rd : '0);
        pop      = out_vld & m_axis.tready;
        // Never more reads in flight than the skid can absorb with tready low.
        issue    = (rd_ptr_q != wr_ptr_q) && ((3'(sk_cnt_q) + 3'(rd_vld_q)) <= 3'd1);
        rd_ptr_d = rd_ptr_q + PW'(issue);

        sk_d     = sk_q;
        sk_cnt_d = sk_cnt_q;
        if (pop && sk_cnt_q != 2'd0) begin
            sk_d[0]  = sk_q[1];
            sk_cnt_d = sk_cnt_q - 2'd1;
        end
        if (rd_vld_q && !(pop && sk_cnt_q == 2'd0)) begin
            sk_d[sk_cnt_d[0]] = ram_rd;
            sk_cnt_d          = sk_cnt_d + 2'd1;
        end

        sent_cnt_d = sent_cnt_q + 32'(pop & out_beat.last);
    end

    always_ff @(posedge net_clk or posedge sys_reset) begin
        if (sys_reset) begin
            rd_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            sk_cnt_q   <= '0;
            sk_q       <= '{default: '0};
            sent_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_vld_q   <= issue;
            sk_cnt_q   <= sk_cnt_d;
            sk_q       <= sk_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_beat.data;
    assign m_axis.tkeep  = out_beat.keep;
    assign m_axis.tlast  = out_beat.last;
    assign pkt_sent_cnt  = sent_cnt_q;
    assign pkt_drop_cnt  = drop_cnt_q;
    assign fill_level    = wr_tmp_q - rd_ptr_q;

endmodule

// File: doc/net_tx_pkt_buffer.md
Name: net_tx_pkt_buffer

Overview:
- Parametrised store-and-forward TX packet buffer in the net_clk domain, placed directly before the CMAC TX register slice.
- Supersedes the fixed 512-bit padding IP plus packet FIFO pair with one block that pads runt frames to a minimum length.
- Drops oversize or overflowing packets whole; never back-pressures its upstream mid-packet.
- Releases only complete packets, so each packet reaches the MAC as one gap-free burst. Exports drop and send counters.

Parameters:
- DATA_W, 512: data width in bits; multiple of 64; keep width is DATA_W/8.
- DEPTH, 256: buffer depth in beats; power of 2, at least 2*MAX_PKT_BEATS.
- MAX_PKT_BEATS, 32: packets longer than this many beats are dropped.
- MIN_FRAME_BYTES, 60: minimum frame length before FCS; must be ≤ DATA_W/8.

Ports:
- net_clk  in  1  clock.
- sys_reset  in  1  reset; asynchronous, active-high.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tready  out  1  ingress ready.
- s_axis_tdata  in  DATA_W  ingress data.
- s_axis_tkeep  in  DATA_W/8  ingress keep; contiguous from bit 0.
- s_axis_tlast  in  1  ingress end of packet.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tready  in  1  egress ready.
- m_axis_tdata  out  DATA_W  egress data.
- m_axis_tkeep  out  DATA_W/8  egress keep.
- m_axis_tlast  out  1  egress end of packet.
- pkt_sent_cnt  out  32  packets fully emitted; wraps.
- pkt_drop_cnt  out  32  packets dropped; wraps.
- fill_level  out  $clog2(DEPTH)+1  committed-plus-pending beats held.

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, both counters 0, fill_level 0, all pointers 0, write FSM in IDLE.
- s_axis_tready is 1 from the first cycle after reset deasserts. The ingress is never stalled; overflow is handled by dropping.
- Pointers: wr_ptr (commit), wr_tmp (speculative) and rd_ptr are each $clog2(DEPTH)+1 bits with a wrap bit.
  - Full when wr_tmp and rd_ptr differ only in the MSB.
  - Empty-of-committed when rd_ptr == wr_ptr.
- Write FSM:
  - IDLE --beat accepted--> ACCEPT (a one-beat packet commits directly and stays in IDLE).
  - ACCEPT --last--> IDLE with commit.
  - ACCEPT --full or beat count > MAX_PKT_BEATS--> DROP.
  - DROP --last--> IDLE.
- On commit, wr_ptr <= wr_tmp + 1 in the cycle the last beat is written.
- On entering DROP:
  - wr_tmp <= wr_ptr, discarding the partial packet.
  - The beat that caused the overflow is discarded.
  - pkt_drop_cnt increments once, when last is seen.
  - If the overflow beat is itself last, the FSM goes straight to IDLE and the count increments in that cycle.
- Padding, applied on the last beat only:
  - Packet byte count = 64-byte-granular beats before the last, plus popcount(last keep).
  - If the count is < MIN_FRAME_BYTES, keep is extended to cover MIN_FRAME_BYTES and the added bytes are written as 0x00.
  - Only single-beat packets can be runts, because MIN_FRAME_BYTES ≤ DATA_W/8.
- Read side:
  - One-cycle synchronous RAM read plus a 2-entry output skid.
  - A packet becomes readable in the cycle after its commit.
  - The first beat reaches m_axis_tvalid 2 cycles after commit when egress is idle.
  - Once started, a packet streams with tvalid held high until last, because the whole packet is resident.
  - Packets are emitted back-to-back with no idle cycle between them when ready=1.
- pkt_sent_cnt increments when a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast is transferred.
- fill_level = wr_tmp − rd_ptr, updated every cycle.
- Simultaneous commit and read are allowed. rd_ptr never passes wr_ptr.
- Async reset mid-packet discards all contents, both partial and committed, with no output glitch beyond deasserting tvalid.

Decomposition:
- Package net_buf_pkg:
  - ptr_t width function.
  - popcount function for keep.
  - Padding-mask function, keep_pad(keep, min_bytes).
  - Write FSM state enum {IDLE, ACCEPT, DROP}.
- One sub-module, net_buf_ram: simple dual-port RAM, DEPTH × (DATA_W + DATA_W/8 + 1), registered read, no reset on the array.

Test Plan:
- 3-beat packet of 192 B, all keep=all-ones, egress ready=1 → emitted unchanged; first m_tvalid 2 cycles after the last input beat; pkt_sent_cnt=1.
- 1-beat packet with keep=0x0000_0000_0000_FFFF (16 B) → out keep=0x0FFF_FFFF_FFFF_FFFF; bytes 16..59 = 0x00; bytes 0..15 match the input.
- 40-beat packet with MAX_PKT_BEATS=32 → nothing emitted; pkt_drop_cnt=1; fill_level returns to 0; a following 2-beat packet is emitted intact.
- Egress ready=0; write 8 packets of 32 beats each with DEPTH=256, then a 9th packet → the 9th is dropped on the full beat; ready=1 → exactly 8 packets out; pkt_sent_cnt=8; pkt_drop_cnt=1.
- Egress ready toggling 1/0 every cycle while two 4-beat packets stream in → output order and data intact, last asserted on beats 4 and 8, no lost or duplicated beat.
- sys_reset pulsed while a 5-beat packet is half written and one committed packet is pending → after reset m_tvalid=0, fill_level=0, counters=0; a new packet passes normally.
